// File: rtl/can_bit_timing.sv
// CAN bit-timing generator: tq prescaler, SYNC/PROP/PS1/PS2 segments,
// sample point, hard sync and SJW-limited resynchronisation.
module can_bit_timing #(
  parameter int PRESC_W  = 8,
  parameter int SEG_W    = 4,
  parameter int DEF_BRP  = 4,
  parameter int DEF_PROP = 3,
  parameter int DEF_PS1  = 3,
  parameter int DEF_PS2  = 3,
  parameter int DEF_SJW  = 0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] brp_i,
  input  logic [SEG_W-1:0]   prop_seg_i,
  input  logic [SEG_W-1:0]   phase_seg1_i,
  input  logic [SEG_W-1:0]   phase_seg2_i,
  input  logic [1:0]         sjw_i,
  input  logic               rx_i,
  input  logic               hard_sync_en_i,
  input  logic               resync_en_i,
  output logic               tq_tick_o,
  output logic               bit_start_o,
  output logic               sample_o,
  output logic               rx_bit_o,
  output logic               can_clk_o,
  output logic [1:0]         seg_o
);

  localparam int CW = SEG_W + 1;
  localparam int EW = SEG_W + 2;

  typedef enum logic [1:0] {
    SEG_SYNC = 2'd0,
    SEG_PROP = 2'd1,
    SEG_PS1  = 2'd2,
    SEG_PS2  = 2'd3
  } seg_e;

  seg_e               seg;
  logic               active;
  logic               rx_m, rx_s, rx_d;
  logic               rx_edge;
  logic               synced;
  logic               rx_bit;
  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] brp_sh;
  logic [PRESC_W-1:0] brp_eff;
  logic [SEG_W-1:0]   prop_sh, ps1_sh, ps2_sh;
  logic [1:0]         sjw_sh;
  logic [CW-1:0]      tq_cnt;
  logic [CW-1:0]      ps1_ext, ps2_red;
  logic [CW-1:0]      prop_len, ps1_len, ps2_len;
  logic [CW-1:0]      sjw_eff, seg_len, ps2_rem, ext_new;
  logic [EW-1:0]      e_val;
  logic               seg_last;
  logic               hard, resync, ps2_cut;

  assign rx_edge = rx_d & ~rx_s;

  assign prop_len = (prop_sh == '0) ? CW'(1) : CW'(prop_sh);
  assign ps1_len  = (ps1_sh == '0)  ? CW'(1) : CW'(ps1_sh);
  assign ps2_len  = (ps2_sh == '0)  ? CW'(1) : CW'(ps2_sh);
  assign sjw_eff  = CW'(sjw_sh) + CW'(1);

  assign bit_start_o = active & (seg == SEG_SYNC)
                     & (tq_cnt == '0) & (presc_cnt == '0);
  // the first SYNC clk already runs on the freshly loaded prescaler
  assign brp_eff   = bit_start_o ? brp_i : brp_sh;
  assign tq_tick_o = active & (presc_cnt == brp_eff);

  always_comb begin
    seg_len = CW'(1);
    unique case (seg)
      SEG_SYNC: seg_len = CW'(1);
      SEG_PROP: seg_len = prop_len;
      SEG_PS1:  seg_len = ps1_len + ps1_ext;
      SEG_PS2:  seg_len = ps2_len - ps2_red;
    endcase
  end

  assign seg_last  = tq_cnt >= (seg_len - CW'(1));
  assign sample_o  = tq_tick_o & (seg == SEG_PS1) & seg_last;
  assign can_clk_o = active & (seg != SEG_PS2);
  assign rx_bit_o  = rx_bit;
  assign seg_o     = seg;

  assign hard   = active & rx_edge & hard_sync_en_i;
  assign resync = active & rx_edge & resync_en_i
                & ~hard_sync_en_i & ~synced;

  // phase error in tq since SYNC, clipped to SJW
  assign e_val = (seg == SEG_PS1)
               ? EW'(prop_len) + EW'(tq_cnt) + EW'(1)
               : EW'(tq_cnt) + EW'(1);
  assign ext_new = (e_val < EW'(sjw_eff)) ? CW'(e_val) : sjw_eff;

  assign ps2_rem = ps2_len - tq_cnt;
  assign ps2_cut = resync & (seg == SEG_PS2) & (ps2_rem <= sjw_eff);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      rx_bit    <= 1'b1;
      active    <= 1'b0;
      seg       <= SEG_SYNC;
      presc_cnt <= '0;
      tq_cnt    <= '0;
      ps1_ext   <= '0;
      ps2_red   <= '0;
      synced    <= 1'b0;
      brp_sh    <= PRESC_W'(DEF_BRP);
      prop_sh   <= SEG_W'(DEF_PROP);
      ps1_sh    <= SEG_W'(DEF_PS1);
      ps2_sh    <= SEG_W'(DEF_PS2);
      sjw_sh    <= 2'(DEF_SJW);
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
      if (sample_o) rx_bit <= rx_s;

      if (!en_i) begin
        active    <= 1'b0;
        seg       <= SEG_SYNC;
        presc_cnt <= '0;
        tq_cnt    <= '0;
        ps1_ext   <= '0;
        ps2_red   <= '0;
        synced    <= 1'b0;
      end else if (!active) begin
        active <= 1'b1;
      end else if (hard || ps2_cut) begin
        seg       <= SEG_SYNC;
        presc_cnt <= '0;
        tq_cnt    <= '0;
        ps1_ext   <= '0;
        ps2_red   <= '0;
        synced    <= 1'b1;
      end else begin
        if (bit_start_o) begin
          brp_sh  <= brp_i;
          prop_sh <= prop_seg_i;
          ps1_sh  <= phase_seg1_i;
          ps2_sh  <= phase_seg2_i;
          sjw_sh  <= sjw_i;
          ps1_ext <= '0;
          ps2_red <= '0;
        end
        if (tq_tick_o) begin
          presc_cnt <= '0;
          if (seg_last) begin
            tq_cnt <= '0;
            unique case (seg)
              SEG_SYNC: seg <= SEG_PROP;
              SEG_PROP: seg <= SEG_PS1;
              SEG_PS1:  seg <= SEG_PS2;
              SEG_PS2:  seg <= SEG_SYNC;
            endcase
          end else begin
            tq_cnt <= tq_cnt + CW'(1);
          end
        end else begin
          presc_cnt <= presc_cnt + PRESC_W'(1);
        end
        if (sample_o) synced <= 1'b0;
        if (resync) begin
          synced <= 1'b1;
          unique case (seg)
            SEG_PROP: ps1_ext <= ext_new;
            SEG_PS1:  ps1_ext <= ext_new;
            SEG_PS2:  ps2_red <= sjw_eff;
            default:  ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
Parametrised CAN bit-timing generator. Successor to the fixed-divide CAN clock block: it adds a programmable time-quantum prescaler, SYNC/PROP/PS1/PS2 segments, sample-point generation, hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant edges. It sits between the system clock and the CAN bit stream / MAC logic and provides bit-start and sample strobes plus the sampled RX bit.

Parameters:
PRESC_W, 8, width of brp_i
SEG_W, 4, width of segment-length inputs
DEF_BRP, 4, reset value of brp shadow (5 clk/tq)
DEF_PROP, 3, reset value of prop shadow (tq)
DEF_PS1, 3, reset value of PS1 shadow (tq)
DEF_PS2, 3, reset value of PS2 shadow (tq)
DEF_SJW, 0, reset value of SJW shadow (encoded; effective SJW 1 tq)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
en_i  in  1  0: hold timing engine idle
brp_i  in  PRESC_W  tq length = brp_i+1 clk
prop_seg_i  in  SEG_W  PROP length, tq (0 treated as 1)
phase_seg1_i  in  SEG_W  PS1 length, tq (0 treated as 1)
phase_seg2_i  in  SEG_W  PS2 length, tq (0 treated as 1)
sjw_i  in  2  effective SJW = sjw_i+1 tq (1..4)
rx_i  in  1  raw CAN RX, asynchronous
hard_sync_en_i  in  1  bus idle / SOF window: edges cause hard sync
resync_en_i  in  1  enable resynchronisation
tq_tick_o  out  1  one-clk pulse at last clk of each tq
bit_start_o  out  1  one-clk pulse at first clk of SYNC (TX point)
sample_o  out  1  one-clk pulse at sample point
rx_bit_o  out  1  RX value captured at last sample point
can_clk_o  out  1  high from SYNC start to sample point, low from sample point to bit end
seg_o  out  2  current segment: 0 SYNC, 1 PROP, 2 PS1, 3 PS2

Behaviour:
- Reset (async, rst_n_i=0): seg SYNC; presc_cnt, tq_cnt 0; tq_tick_o, bit_start_o, sample_o, can_clk_o 0; rx_bit_o 1; RX sync flops 1; shadows = DEF_*; ps1_ext 0; synced flag 0. Reset release mid-bit restarts from a fresh SYNC.
- rx_i passes through a 2-FF synchroniser (rx_s) and one history flop (rx_d). Edge = rx_d & ~rx_s (falling only). Detection lags the bus by 2-3 clk.
- Prescaler: presc_cnt counts 0..brp_sh; tq_tick_o = (presc_cnt == brp_sh) & en_i. With brp=0, tick every clk.
- Segment FSM advances only on tq_tick. tq_cnt indexes tq within segment (0-based). SYNC = 1 tq; PROP = prop_sh tq; PS1 = ps1_sh + ps1_ext tq; PS2 = ps2_sh tq (reducible, see below). Last tq of PS2 -> SYNC.
- bit_start_o: first clk of SYNC. Shadows load from the *_i inputs on this clk. Config changes mid-bit take effect at the next bit. can_clk_o set here.
- sample_o: on the tick ending PS1. rx_bit_o <= rx_s on the following clk. can_clk_o cleared with sample_o. synced flag cleared at sample_o.
- Hard sync (edge & hard_sync_en_i; overrides resync; ignores synced flag): next clk seg=SYNC, presc_cnt=0, tq_cnt=0, ps1_ext=0, bit_start_o=1. Sets synced.
- Resync (edge & resync_en_i & ~hard_sync_en_i & ~synced). Sets synced. Actions by segment:
  - SYNC: no action.
  - PROP idx i: e = i+1.
  - PS1 idx i: e = prop_sh+i+1.
  - For PROP/PS1: ps1_ext = min(e, sjw).
  - PS2: r = ps2_sh - tq_cnt. If r <= sjw, next clk is SYNC with presc_cnt=0 (bit shortened). Otherwise PS2 end moves to ps2_sh - sjw tq.
- ps1_ext clears at bit_start. Edge coincident with tq_tick: the edge is attributed to the segment/tq before the tick.
- en_i=0: FSM held in SYNC; counters 0; strobes 0; can_clk_o 0; synchroniser keeps running. On en_i rising, bit_start_o fires on the next clk.
- Bit length = (1+prop+ps1+ps2)*(brp+1) clk. Max 46 tq with SEG_W=4.

Test Plan:
- Defaults, en_i=1, rx_i=1: bit_start_o at clk 0, 50, 100. tq_tick_o every 5 clk (clk 4, 9, ...). sample_o at clk 34. can_clk_o high clk 0-34, low 35-49. seg_o sequence 0,1,2,3.
- rx_i driven 0 before sample, then 1 the following bit: rx_bit_o = 0 from clk 35, = 1 from clk 85.
- Resync in PS1: edge detected in PS1 tq idx 1, sjw_i=0. PS1 extended by 1 tq: sample_o at clk 39, next bit_start_o at clk 55. A second edge in the same bit is ignored.
- Resync in PS2: edge detected in last PS2 tq, sjw_i=0. bit_start_o on the following clk, presc restarts. With sjw_i=3 and edge in PS2 idx 0, the bit ends immediately.
- Hard sync: hard_sync_en_i=1, edge mid-PS1. bit_start_o 1 clk after detection, no sample_o for the aborted bit, sample_o 34 clk after the new bit_start_o.
- Config and reset: change brp_i to 9 mid-bit -> current bit stays 50 clk, next bit 100 clk. Assert rst_n_i low mid-PS2 -> all outputs 0 (rx_bit_o 1) immediately, without a clock edge.
